// File: rtl/id_pipe_if.sv
// Handshake and ID/EX result bundle for the decode stage.
interface id_pipe_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           pc_i;
  logic [31:0]           inst_i;
  logic                  out_valid;
  logic                  out_ready;
  logic [31:0]           pc_o;
  logic [7:0]            aluop_o;
  logic [2:0]            alusel_o;
  logic [DATA_W-1:0]     reg1_o;
  logic [DATA_W-1:0]     reg2_o;
  logic [REG_ADDR_W-1:0] wd_o;
  logic                  wreg_o;
  logic                  inst_invalid_o;
  logic [CNT_W-1:0]      invalid_cnt_o;

  // Upstream/downstream side: drives beats in, consumes results.
  modport master (
    output in_valid, pc_i, inst_i, out_ready,
    input  in_ready, out_valid, pc_o, aluop_o, alusel_o, reg1_o, reg2_o,
           wd_o, wreg_o, inst_invalid_o, invalid_cnt_o
  );

  // Decode stage side.
  modport slave (
    input  in_valid, pc_i, inst_i, out_ready,
    output in_ready, out_valid, pc_o, aluop_o, alusel_o, reg1_o, reg2_o,
           wd_o, wreg_o, inst_invalid_o, invalid_cnt_o
  );
endinterface

// File: rtl/id_pipe.sv
// Registered ID stage: logic-subset decode, EX/MEM forwarding, ID/EX register.
module id_pipe #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter bit FWD_EN     = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  id_pipe_if.slave              bus,
  output logic                  reg1_read_o,
  output logic                  reg2_read_o,
  output logic [REG_ADDR_W-1:0] reg1_addr_o,
  output logic [REG_ADDR_W-1:0] reg2_addr_o,
  input  logic [DATA_W-1:0]     reg1_data_i,
  input  logic [DATA_W-1:0]     reg2_data_i,
  input  logic                  ex_wreg_i,
  input  logic [REG_ADDR_W-1:0] ex_wd_i,
  input  logic [DATA_W-1:0]     ex_wdata_i,
  input  logic                  mem_wreg_i,
  input  logic [REG_ADDR_W-1:0] mem_wd_i,
  input  logic [DATA_W-1:0]     mem_wdata_i,
  input  logic                  flush_i
);

  typedef enum logic [7:0] {
    ALU_NOP = 8'h00,
    ALU_AND = 8'h24,
    ALU_OR  = 8'h25,
    ALU_XOR = 8'h26,
    ALU_NOR = 8'h27
  } aluop_e;

  typedef enum logic [2:0] {
    SEL_NOP   = 3'b000,
    SEL_LOGIC = 3'b001
  } alusel_e;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] FN_AND     = 6'b100100;
  localparam logic [5:0] FN_OR      = 6'b100101;
  localparam logic [5:0] FN_XOR     = 6'b100110;
  localparam logic [5:0] FN_NOR     = 6'b100111;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [5:0]            op;
  logic [5:0]            funct;
  logic [4:0]            shamt;
  aluop_e                dec_aluop;
  alusel_e               dec_alusel;
  logic [REG_ADDR_W-1:0] dec_wd;
  logic                  dec_wreg;
  logic                  dec_invalid;
  logic                  dec_lui;
  logic [DATA_W-1:0]     imm;
  logic [DATA_W-1:0]     opnd1;
  logic [DATA_W-1:0]     opnd2;
  logic                  accept;

  assign op          = bus.inst_i[31:26];
  assign funct       = bus.inst_i[5:0];
  assign shamt       = bus.inst_i[10:6];
  assign reg1_addr_o = bus.inst_i[25:21];
  assign reg2_addr_o = bus.inst_i[20:16];
  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept      = bus.in_valid && bus.in_ready && !flush_i;

  // Instruction decode.
  always_comb begin
    dec_aluop   = ALU_NOP;
    dec_alusel  = SEL_NOP;
    dec_wd      = '0;
    dec_wreg    = 1'b0;
    dec_invalid = 1'b0;
    dec_lui     = 1'b0;
    reg1_read_o = 1'b0;
    reg2_read_o = 1'b0;
    imm         = '0;
    if (bus.inst_i == 32'h0) begin
      dec_invalid = 1'b0;
    end else begin
      case (op)
        OP_ORI, OP_ANDI, OP_XORI: begin
          dec_alusel  = SEL_LOGIC;
          reg1_read_o = 1'b1;
          imm[15:0]   = bus.inst_i[15:0];
          dec_wd      = bus.inst_i[20:16];
          dec_wreg    = 1'b1;
          dec_aluop   = (op == OP_ORI)  ? ALU_OR :
                        (op == OP_ANDI) ? ALU_AND : ALU_XOR;
        end
        OP_LUI: begin
          dec_alusel = SEL_LOGIC;
          dec_aluop  = ALU_OR;
          dec_lui    = 1'b1;
          imm[31:16] = bus.inst_i[15:0];
          dec_wd     = bus.inst_i[20:16];
          dec_wreg   = 1'b1;
        end
        OP_SPECIAL: begin
          if (shamt == 5'd0 && (funct == FN_AND || funct == FN_OR ||
                                funct == FN_XOR || funct == FN_NOR)) begin
            dec_alusel  = SEL_LOGIC;
            reg1_read_o = 1'b1;
            reg2_read_o = 1'b1;
            dec_wd      = bus.inst_i[15:11];
            dec_wreg    = 1'b1;
            case (funct)
              FN_AND:  dec_aluop = ALU_AND;
              FN_OR:   dec_aluop = ALU_OR;
              FN_XOR:  dec_aluop = ALU_XOR;
              default: dec_aluop = ALU_NOR;
            endcase
          end else begin
            dec_invalid = 1'b1;
          end
        end
        default: dec_invalid = 1'b1;
      endcase
    end
    if (dec_wd == '0) dec_wreg = 1'b0;
  end

  // Zero register, then EX, then MEM, then regfile; disabled ports take the immediate path.
  function automatic logic [DATA_W-1:0] pick(
    input logic                  rd,
    input logic [REG_ADDR_W-1:0] addr,
    input logic [DATA_W-1:0]     rf,
    input logic [DATA_W-1:0]     alt,
    input logic                  exw,
    input logic [REG_ADDR_W-1:0] exd,
    input logic [DATA_W-1:0]     exv,
    input logic                  memw,
    input logic [REG_ADDR_W-1:0] memd,
    input logic [DATA_W-1:0]     memv
  );
    if (!rd)                                return alt;
    if (addr == '0)                         return '0;
    if (FWD_EN && exw && exd == addr)       return exv;
    if (FWD_EN && memw && memd == addr)     return memv;
    return rf;
  endfunction

  // Operand selection for both read ports.
  always_comb begin
    opnd1 = pick(reg1_read_o, reg1_addr_o, reg1_data_i, dec_lui ? '0 : imm,
                 ex_wreg_i, ex_wd_i, ex_wdata_i, mem_wreg_i, mem_wd_i, mem_wdata_i);
    opnd2 = pick(reg2_read_o, reg2_addr_o, reg2_data_i, imm,
                 ex_wreg_i, ex_wd_i, ex_wdata_i, mem_wreg_i, mem_wd_i, mem_wdata_i);
  end

  // ID/EX register with handshake, flush and invalid counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid      <= 1'b0;
      bus.pc_o           <= '0;
      bus.aluop_o        <= ALU_NOP;
      bus.alusel_o       <= SEL_NOP;
      bus.reg1_o         <= '0;
      bus.reg2_o         <= '0;
      bus.wd_o           <= '0;
      bus.wreg_o         <= 1'b0;
      bus.inst_invalid_o <= 1'b0;
      bus.invalid_cnt_o  <= '0;
    end else begin
      if (flush_i) begin
        bus.out_valid <= 1'b0;
      end else if (accept) begin
        bus.out_valid      <= 1'b1;
        bus.pc_o           <= bus.pc_i;
        bus.aluop_o        <= dec_aluop;
        bus.alusel_o       <= dec_alusel;
        bus.reg1_o         <= opnd1;
        bus.reg2_o         <= opnd2;
        bus.wd_o           <= dec_wd;
        bus.wreg_o         <= dec_wreg;
        bus.inst_invalid_o <= dec_invalid;
        if (dec_invalid && bus.invalid_cnt_o != '1)
          bus.invalid_cnt_o <= bus.invalid_cnt_o + CNT_ONE;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_id_pipe.sv
// Directed bench for id_pipe: three instances (forwarding, no forwarding, 2-bit counter).
module tb_id_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        out_ready;
  logic        flush;
  logic [31:0] rf1, rf2;
  logic        exw, memw;
  logic [4:0]  exd, memd;
  logic [31:0] exv, memv;

  int unsigned checks = 0;
  int unsigned errors = 0;

  id_pipe_if #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(16)) bus_a ();
  id_pipe_if #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(16)) bus_b ();
  id_pipe_if #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(2))  bus_c ();

  assign bus_a.in_valid = in_valid;  assign bus_a.pc_i = pc;  assign bus_a.inst_i = inst;  assign bus_a.out_ready = out_ready;
  assign bus_b.in_valid = in_valid;  assign bus_b.pc_i = pc;  assign bus_b.inst_i = inst;  assign bus_b.out_ready = out_ready;
  assign bus_c.in_valid = in_valid;  assign bus_c.pc_i = pc;  assign bus_c.inst_i = inst;  assign bus_c.out_ready = out_ready;

  logic       r1_rd_a, r2_rd_a, r1_rd_b, r2_rd_b, r1_rd_c, r2_rd_c;
  logic [4:0] r1_ad_a, r2_ad_a, r1_ad_b, r2_ad_b, r1_ad_c, r2_ad_c;

  id_pipe #(.DATA_W(32), .REG_ADDR_W(5), .FWD_EN(1'b1), .CNT_W(16)) u_fwd (
    .clk(clk), .rst(rst), .bus(bus_a),
    .reg1_read_o(r1_rd_a), .reg2_read_o(r2_rd_a), .reg1_addr_o(r1_ad_a), .reg2_addr_o(r2_ad_a),
    .reg1_data_i(rf1), .reg2_data_i(rf2),
    .ex_wreg_i(exw), .ex_wd_i(exd), .ex_wdata_i(exv),
    .mem_wreg_i(memw), .mem_wd_i(memd), .mem_wdata_i(memv), .flush_i(flush)
  );

  id_pipe #(.DATA_W(32), .REG_ADDR_W(5), .FWD_EN(1'b0), .CNT_W(16)) u_nofwd (
    .clk(clk), .rst(rst), .bus(bus_b),
    .reg1_read_o(r1_rd_b), .reg2_read_o(r2_rd_b), .reg1_addr_o(r1_ad_b), .reg2_addr_o(r2_ad_b),
    .reg1_data_i(rf1), .reg2_data_i(rf2),
    .ex_wreg_i(exw), .ex_wd_i(exd), .ex_wdata_i(exv),
    .mem_wreg_i(memw), .mem_wd_i(memd), .mem_wdata_i(memv), .flush_i(flush)
  );

  id_pipe #(.DATA_W(32), .REG_ADDR_W(5), .FWD_EN(1'b1), .CNT_W(2)) u_cnt2 (
    .clk(clk), .rst(rst), .bus(bus_c),
    .reg1_read_o(r1_rd_c), .reg2_read_o(r2_rd_c), .reg1_addr_o(r1_ad_c), .reg2_addr_o(r2_ad_c),
    .reg1_data_i(rf1), .reg2_data_i(rf2),
    .ex_wreg_i(exw), .ex_wd_i(exd), .ex_wdata_i(exv),
    .mem_wreg_i(memw), .mem_wd_i(memd), .mem_wdata_i(memv), .flush_i(flush)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat for a single edge, then withdraw it.
  task automatic beat(input logic [31:0] p, input logic [31:0] i);
    pc = p;
    inst = i;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic check_main(input string tag, input logic [31:0] r1, input logic [31:0] r2,
                            input logic [7:0] op, input logic [4:0] wd, input logic wr);
    check({tag, ".valid"}, bus_a.out_valid, 1'b1);
    check({tag, ".reg1"},  bus_a.reg1_o, r1);
    check({tag, ".reg2"},  bus_a.reg2_o, r2);
    check({tag, ".aluop"}, bus_a.aluop_o, op);
    check({tag, ".wd"},    bus_a.wd_o, wd);
    check({tag, ".wreg"},  bus_a.wreg_o, wr);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; pc = '0; inst = '0; out_ready = 1'b1; flush = 1'b0;
    rf1 = '0; rf2 = '0; exw = 1'b0; memw = 1'b0; exd = '0; memd = '0; exv = '0; memv = '0;
    step();
    step();
    check("rst.valid", bus_a.out_valid, 1'b0);
    check("rst.aluop", bus_a.aluop_o, 8'h00);
    check("rst.cnt",   bus_a.invalid_cnt_o, 16'd0);
    check("rst.ready", bus_a.in_ready, 1'b1);
    rst = 1'b0;
    step();

    // ori $1,$0,0x1100
    inst = 32'h3401_1100;
    #1;
    check("ori.rd1", r1_rd_a, 1'b1);
    check("ori.rd2", r2_rd_a, 1'b0);
    check("ori.ad2", r2_ad_a, 5'd1);
    rf1 = 32'h0000_BEEF;
    beat(32'h0000_0100, 32'h3401_1100);
    check_main("ori1", 32'h0, 32'h1100, 8'h25, 5'd1, 1'b1);
    check("ori1.sel", bus_a.alusel_o, 3'b001);
    check("ori1.pc",  bus_a.pc_o, 32'h0000_0100);

    // ori $2,$1,0x20 with EX forwarding $1
    exw = 1'b1; exd = 5'd1; exv = 32'h0000_1100; rf1 = 32'h0000_DEAD;
    beat(32'h0000_0104, 32'h3422_0020);
    check_main("ori2", 32'h1100, 32'h20, 8'h25, 5'd2, 1'b1);
    check("ori2.nofwd", bus_b.reg1_o, 32'h0000_DEAD);

    // Stall: held outputs ignore later forward data and pending beats
    out_ready = 1'b0;
    exv = 32'hFFFF_FFFF;
    pc = 32'h0000_0200; inst = 32'h3403_0001; in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check("stall.valid", bus_a.out_valid, 1'b1);
      check("stall.ready", bus_a.in_ready, 1'b0);
      check("stall.reg1",  bus_a.reg1_o, 32'h1100);
      check("stall.pc",    bus_a.pc_o, 32'h0000_0104);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush.valid", bus_a.out_valid, 1'b0);
    out_ready = 1'b1;
    step();
    check("flush.drop", bus_a.out_valid, 1'b0);
    check("flush.pc",   bus_a.pc_o, 32'h0000_0104);

    // or $4,$3,$3 with EX and MEM both writing $3
    exw = 1'b1; exd = 5'd3; exv = 32'h0000_AAAA;
    memw = 1'b1; memd = 5'd3; memv = 32'h0000_5555;
    rf1 = 32'h1234_5678; rf2 = 32'h1234_5678;
    beat(32'h0000_0300, 32'h0063_2025);
    check_main("or", 32'hAAAA, 32'hAAAA, 8'h25, 5'd4, 1'b1);
    check("or.nofwd1", bus_b.reg1_o, 32'h1234_5678);
    check("or.nofwd2", bus_b.reg2_o, 32'h1234_5678);

    // xor $6,$3,$9: MEM hit on port 1, EX hit on port 2
    exd = 5'd9;
    beat(32'h0000_0304, 32'h0069_3026);
    check_main("xor", 32'h5555, 32'hAAAA, 8'h26, 5'd6, 1'b1);

    // nor $7,$3,$3 with write enables low: no forwarding
    exw = 1'b0; exd = 5'd3; memw = 1'b0;
    beat(32'h0000_0308, 32'h0063_3827);
    check_main("nor", 32'h1234_5678, 32'h1234_5678, 8'h27, 5'd7, 1'b1);

    // lui $5,0x1234
    inst = 32'h3C05_1234;
    #1;
    check("lui.rd1", r1_rd_a, 1'b0);
    check("lui.rd2", r2_rd_a, 1'b0);
    beat(32'h0000_030C, 32'h3C05_1234);
    check_main("lui", 32'h0, 32'h1234_0000, 8'h25, 5'd5, 1'b1);

    // andi $0,$2,0xFFFF: destination $0 forces wreg low
    beat(32'h0000_0310, 32'h3040_FFFF);
    check_main("andi0", 32'h1234_5678, 32'h0000_FFFF, 8'h24, 5'd0, 1'b0);

    // All-zero word is a valid NOP
    beat(32'h0000_0314, 32'h0000_0000);
    check("nop.aluop", bus_a.aluop_o, 8'h00);
    check("nop.sel",   bus_a.alusel_o, 3'b000);
    check("nop.inv",   bus_a.inst_invalid_o, 1'b0);
    check("nop.wreg",  bus_a.wreg_o, 1'b0);

    // Invalid opcode twice
    beat(32'h0000_0318, 32'hFC00_0000);
    check("inv1.inv",  bus_a.inst_invalid_o, 1'b1);
    check("inv1.wreg", bus_a.wreg_o, 1'b0);
    check("inv1.cnt",  bus_a.invalid_cnt_o, 16'd1);
    beat(32'h0000_031C, 32'hFC00_0000);
    check("inv2.inv",  bus_a.inst_invalid_o, 1'b1);
    check("inv2.cnt",  bus_a.invalid_cnt_o, 16'd2);

    // R-type with non-zero shamt is invalid
    beat(32'h0000_0320, 32'h0063_2065);
    check("shamt.inv", bus_a.inst_invalid_o, 1'b1);
    check("shamt.cnt", bus_a.invalid_cnt_o, 16'd3);

    // Flushed invalid beat is not counted
    flush = 1'b1;
    beat(32'h0000_0324, 32'hFC00_0000);
    flush = 1'b0;
    check("flinv.valid", bus_a.out_valid, 1'b0);
    check("flinv.cnt",   bus_a.invalid_cnt_o, 16'd3);

    // Two more invalids: five total, 2-bit counter saturates
    beat(32'h0000_0328, 32'hFC00_0000);
    beat(32'h0000_032C, 32'hFC00_0000);
    check("sat.cnt16", bus_a.invalid_cnt_o, 16'd5);
    check("sat.cnt2",  bus_c.invalid_cnt_o, 2'd3);

    // Asynchronous reset while a beat is held
    out_ready = 1'b0;
    beat(32'h0000_0400, 32'h3401_1100);
    check("pre.valid", bus_a.out_valid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("arst.valid", bus_a.out_valid, 1'b0);
    check("arst.pc",    bus_a.pc_o, 32'h0);
    check("arst.reg2",  bus_a.reg2_o, 32'h0);
    check("arst.wd",    bus_a.wd_o, 5'd0);
    check("arst.wreg",  bus_a.wreg_o, 1'b0);
    check("arst.cnt",   bus_a.invalid_cnt_o, 16'd0);
    check("arst.cnt2",  bus_c.invalid_cnt_o, 2'd0);
    step();
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/id_pipe.md
# id_pipe

Parametrised, registered instruction-decode stage for the 5-stage CPU. It sits between the IF/ID register and EX. It decodes the MIPS logic subset (ori/andi/xori/lui and R-type and/or/xor/nor) and resolves RAW hazards by forwarding from EX and MEM. Results are held in an internal ID/EX register behind a valid/ready handshake, with flush and an invalid-instruction counter.

## Interface
- DATA_W, 32, operand/data width; must be ≥32.
- REG_ADDR_W, 5, register address width.
- FWD_EN, 1, 1 = EX/MEM forwarding enabled; 0 = regfile data only.
- CNT_W, 16, width of the invalid-instruction counter.

- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  pc_i/inst_i valid.
- in_ready  out  1  stage can accept; = !out_valid | out_ready (combinational).
- pc_i  in  32  instruction address.
- inst_i  in  32  instruction word.
- reg1_read_o, reg2_read_o  out  1  regfile read enables (combinational from inst_i).
- reg1_addr_o, reg2_addr_o  out  REG_ADDR_W  regfile read addresses, inst_i[25:21] / inst_i[20:16].
- reg1_data_i, reg2_data_i  in  DATA_W  regfile read data (same cycle).
- ex_wreg_i, ex_wd_i, ex_wdata_i  in  1/REG_ADDR_W/DATA_W  EX-stage write-back.
- mem_wreg_i, mem_wd_i, mem_wdata_i  in  1/REG_ADDR_W/DATA_W  MEM-stage write-back.
- flush_i  in  1  discard held and incoming beat.
- out_valid  out  1  ID/EX register valid.
- out_ready  in  1  EX accepts.
- pc_o  out  32  registered pc.
- aluop_o  out  8  ALU sub-op: NOP 8'h00, AND 8'h24, OR 8'h25, XOR 8'h26, NOR 8'h27.
- alusel_o  out  3  result class: NOP 3'b000, LOGIC 3'b001.
- reg1_o, reg2_o  out  DATA_W  source operands.
- wd_o  out  REG_ADDR_W  destination register.
- wreg_o  out  1  write enable.
- inst_invalid_o  out  1  registered beat was undecodable.
- invalid_cnt_o  out  CNT_W  saturating count of accepted invalid instructions.

## Operation
- Decode, by op = inst_i[31:26]:
  - ori 001101 → OR, rs, imm.
  - andi 001100 → AND, rs, imm.
  - xori 001110 → XOR, rs, imm.
  - These three: reg1 read on, reg2 read off, imm = zero-extended inst[15:0], wd = inst[20:16].
  - lui 001111 → OR. Both reads off, reg1 operand = 0, imm = {inst[15:0],16'h0} zero-extended to DATA_W, wd = inst[20:16].
  - op 000000 with funct inst[5:0] = 100100/100101/100110/100111 and inst[10:6]=0 → AND/OR/XOR/NOR. Both reads on, wd = inst[15:11].
  - inst_i == 0 → NOP, valid, wreg 0.
  - Anything else → NOP, wreg 0, invalid.
- Operand select, per port:
  - If the read is enabled: addr 0 gives 0; else EX hit; else MEM hit; else regfile data.
  - A hit needs FWD_EN=1, a matching wd and wreg=1.
  - If the read is disabled: reg1 gets 0 for lui and imm otherwise; reg2 gets imm for I-type and 0 otherwise.
- wreg_o is forced 0 when wd = 0.
- On accept (in_valid & in_ready & !flush_i), all decoded fields load into the ID/EX register and out_valid is set to 1.
- When out_valid & out_ready with no new accept, out_valid clears to 0.
- invalid_cnt_o increments on each accepted invalid beat and saturates at all-ones.

## Timing
- Reset (async, immediate): out_valid 0, pc_o 0, aluop_o 8'h00, alusel_o 3'b000, reg1_o/reg2_o 0, wd_o 0, wreg_o 0, inst_invalid_o 0, invalid_cnt_o 0.
- Latency: beat accepted at edge k appears on outputs after edge k; one beat per cycle at full throughput.
- Forward/regfile data is sampled on the accepting edge only. Later changes to it do not alter held outputs.
- Stall: with out_valid=1 and out_ready=0, all registered outputs stay stable and in_ready=0.
- flush_i at an edge: out_valid←0 and any incoming beat is dropped, even if in_ready=1. A dropped beat does not count toward invalid_cnt_o. Flush wins over a simultaneous accept.
- When EX and MEM both hit the same register, EX wins.
- The read-port outputs (reg*_read_o, reg*_addr_o) are combinational from inst_i, independent of the handshake.

## Test plan
- Reset mid-stream: assert rst asynchronously while out_valid=1 → all outputs go to reset values immediately.
- ori $1,$0,0x1100, then ori $2,$1,0x0020 with EX forwarding $1=0x1100 → second beat gives reg1_o=0x1100, reg2_o=0x0020, aluop 8'h25, wd 2, wreg 1.
- EX and MEM both write $3 (0xAAAA / 0x5555), then or $4,$3,$3 → reg1_o=reg2_o=0x0000AAAA. With FWD_EN=0, both operands equal regfile data instead.
- lui $5,0x1234 → reg1_o=0, reg2_o=0x12340000, aluop OR.
- Hold out_ready=0 for 3 cycles after a beat → outputs stable, in_ready=0. Then pulse flush_i with in_valid=1 → out_valid=0 and the new beat is not taken.
- Feed 0xFC000000 twice → inst_invalid_o=1 and wreg_o=0 on each beat, invalid_cnt_o=2. With CNT_W=2, five invalid beats leave invalid_cnt_o=3.
